// File: rtl/rf_sequencer_pkg.sv
// Shared encodings for the register-file sequencer: opcodes, register
// indices, sequencer states and register-file function codes.
package rf_sequencer_pkg;

  // Command opcodes; 110 and 111 are illegal
  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_MOV  = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;

  // Register indices: T bank in the low half, R bank in the high half
  localparam logic [2:0] IDX_T1 = 3'b000;
  localparam logic [2:0] IDX_T2 = 3'b001;
  localparam logic [2:0] IDX_T3 = 3'b010;
  localparam logic [2:0] IDX_T4 = 3'b011;
  localparam logic [2:0] IDX_R1 = 3'b100;
  localparam logic [2:0] IDX_R2 = 3'b101;
  localparam logic [2:0] IDX_R3 = 3'b110;
  localparam logic [2:0] IDX_R4 = 3'b111;

  // Sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  // Register-file function codes
  localparam logic [1:0] FUN_CLEAR = 2'b00;
  localparam logic [1:0] FUN_LOAD  = 2'b01;
  localparam logic [1:0] FUN_DEC   = 2'b10;
  localparam logic [1:0] FUN_INC   = 2'b11;

  // Function code issued by the single-write opcodes
  function automatic logic [1:0] op_to_fun(input logic [2:0] op);
    case (op)
      OP_LDI:  return FUN_LOAD;
      OP_DEC:  return FUN_DEC;
      OP_INC:  return FUN_INC;
      default: return FUN_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/rf_idx_decode.sv
// Turns a 3-bit register index into the one-hot R or T write enable.
// The MSB picks the bank; the lower bits pick the register, with the
// first register of each bank on bit 3.
module rf_idx_decode (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [3:0] rsel,
  output logic [3:0] tsel
);

  logic [3:0] one_hot;

  // Shift a single bit down from bit 3 and steer it to the selected bank
  always_comb begin
    one_hot = 4'b1000 >> idx[1:0];
    rsel    = (en && idx[2])  ? one_hot : 4'b0000;
    tsel    = (en && !idx[2]) ? one_hot : 4'b0000;
  end

endmodule

// File: rtl/rf_sequencer.sv
// Command sequencer for the register file. It accepts one command at a
// time, breaks it into READ/WRITE steps and drives registered
// register-file controls. SWAP goes through a scratch register in three
// read/write pairs.
module rf_sequencer
  import rf_sequencer_pkg::*;
#(
  parameter logic [2:0] SCRATCH_IDX = IDX_T4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       CmdValid,
  output logic       CmdReady,
  input  logic [2:0] CmdOp,
  input  logic [2:0] CmdDst,
  input  logic [2:0] CmdSrc,
  input  logic [7:0] CmdImm,
  input  logic [7:0] RFOut1,
  output logic [1:0] FunSel,
  output logic [3:0] RSel,
  output logic [3:0] TSel,
  output logic [2:0] O1Sel,
  output logic [2:0] O2Sel,
  output logic [7:0] RFInput,
  output logic       Done,
  output logic       Err
);

  logic [2:0] state, state_n;
  logic [1:0] step, step_n;
  logic [2:0] op_q, op_n;
  logic [2:0] dst_q, dst_n;
  logic [2:0] src_q, src_n;
  logic [1:0] fun_n;
  logic [2:0] o1_n, o2_n;
  logic [7:0] in_n;
  logic       done_n, err_n;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [2:0] swap_wr_idx;
  logic [3:0] rsel_n, tsel_n;

  // The write enables for the next cycle come from the decoded write index
  rf_idx_decode u_decode (
    .idx  (wr_idx),
    .en   (wr_en),
    .rsel (rsel_n),
    .tsel (tsel_n)
  );

  // SWAP writes the scratch register first, then the first operand, then the second
  always_comb begin
    case (step)
      2'd0:    swap_wr_idx = SCRATCH_IDX;
      2'd1:    swap_wr_idx = dst_q;
      default: swap_wr_idx = src_q;
    endcase
  end

  // Next state and next registered outputs; data-path outputs hold unless changed
  always_comb begin
    state_n = state;
    step_n  = step;
    op_n    = op_q;
    dst_n   = dst_q;
    src_n   = src_q;
    fun_n   = FunSel;
    o1_n    = O1Sel;
    o2_n    = 3'b000;
    in_n    = RFInput;
    done_n  = 1'b0;
    err_n   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = 3'b000;
    case (state)
      ST_IDLE: begin
        if (CmdValid && CmdReady) begin
          op_n   = CmdOp;
          dst_n  = CmdDst;
          src_n  = CmdSrc;
          step_n = 2'd0;
          case (CmdOp)
            OP_CLR, OP_LDI, OP_DEC, OP_INC: begin
              state_n = ST_WRITE;
              wr_en   = 1'b1;
              wr_idx  = CmdDst;
              o2_n    = CmdDst;
              fun_n   = op_to_fun(CmdOp);
              in_n    = (CmdOp == OP_LDI) ? CmdImm : 8'h00;
            end
            OP_MOV: begin
              state_n = ST_READ;
              o1_n    = CmdSrc;
            end
            OP_SWAP: begin
              if (CmdDst == SCRATCH_IDX || CmdSrc == SCRATCH_IDX) begin
                state_n = ST_ERR;
                err_n   = 1'b1;
              end else if (CmdDst == CmdSrc) begin
                state_n = ST_DONE;
                done_n  = 1'b1;
              end else begin
                state_n = ST_READ;
                o1_n    = CmdDst;
              end
            end
            default: begin
              state_n = ST_ERR;
              err_n   = 1'b1;
            end
          endcase
        end
      end
      ST_READ: begin
        state_n = ST_WRITE;
        wr_en   = 1'b1;
        wr_idx  = (op_q == OP_MOV) ? dst_q : swap_wr_idx;
        o2_n    = wr_idx;
        fun_n   = FUN_LOAD;
        in_n    = RFOut1;
      end
      ST_WRITE: begin
        if (op_q == OP_SWAP && step != 2'd2) begin
          state_n = ST_READ;
          step_n  = step + 2'd1;
          o1_n    = (step == 2'd0) ? src_q : SCRATCH_IDX;
        end else begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end
      end
      ST_DONE, ST_ERR: state_n = ST_IDLE;
      default:         state_n = ST_IDLE;
    endcase
  end

  // Register the state, the latched command and every output
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      step     <= 2'd0;
      op_q     <= OP_CLR;
      dst_q    <= 3'b000;
      src_q    <= 3'b000;
      FunSel   <= FUN_CLEAR;
      RSel     <= 4'b0000;
      TSel     <= 4'b0000;
      O1Sel    <= 3'b000;
      O2Sel    <= 3'b000;
      RFInput  <= 8'h00;
      Done     <= 1'b0;
      Err      <= 1'b0;
      CmdReady <= 1'b1;
    end else begin
      state    <= state_n;
      step     <= step_n;
      op_q     <= op_n;
      dst_q    <= dst_n;
      src_q    <= src_n;
      FunSel   <= fun_n;
      RSel     <= rsel_n;
      TSel     <= tsel_n;
      O1Sel    <= o1_n;
      O2Sel    <= o2_n;
      RFInput  <= in_n;
      Done     <= done_n;
      Err      <= err_n;
      CmdReady <= (state_n == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer: a simple register file model is attached to the
// control outputs, commands are issued against a reference model, and a
// monitor scores every write, Done, Err and ready edge as it appears.
module tb_rf_sequencer;

  localparam logic [2:0] SCRATCH = 3'b011;
  localparam int EV_WRITE = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;
  localparam int EV_READY = 3;

  typedef struct {
    int         kind;
    logic [2:0] idx;
    logic [1:0] fun;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       CmdValid = 1'b0;
  logic       CmdReady;
  logic [2:0] CmdOp = 3'b000;
  logic [2:0] CmdDst = 3'b000;
  logic [2:0] CmdSrc = 3'b000;
  logic [7:0] CmdImm = 8'h00;
  logic [7:0] RFOut1;
  logic [1:0] FunSel;
  logic [3:0] RSel;
  logic [3:0] TSel;
  logic [2:0] O1Sel;
  logic [2:0] O2Sel;
  logic [7:0] RFInput;
  logic       Done;
  logic       Err;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic prev_ready = 1'b1;
  ev_t  sb[$];
  logic [7:0] rf_env   [8] = '{default: 8'h00};
  logic [7:0] ref_regs [8] = '{default: 8'h00};

  rf_sequencer #(.SCRATCH_IDX(SCRATCH)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .CmdValid (CmdValid),
    .CmdReady (CmdReady),
    .CmdOp    (CmdOp),
    .CmdDst   (CmdDst),
    .CmdSrc   (CmdSrc),
    .CmdImm   (CmdImm),
    .RFOut1   (RFOut1),
    .FunSel   (FunSel),
    .RSel     (RSel),
    .TSel     (TSel),
    .O1Sel    (O1Sel),
    .O2Sel    (O2Sel),
    .RFInput  (RFInput),
    .Done     (Done),
    .Err      (Err)
  );

  // Free-running clock and a cycle count used to time every expected event
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Register file model: index 0-3 are T1-T4, 4-7 are R1-R4
  function automatic logic [7:0] rf_apply(input logic [1:0] f, input logic [7:0] cur,
                                          input logic [7:0] din);
    case (f)
      2'b00:   return 8'h00;
      2'b01:   return din;
      2'b10:   return cur - 8'd1;
      default: return cur + 8'd1;
    endcase
  endfunction

  assign RFOut1 = rf_env[O1Sel];

  // The register file applies the requested function to every enabled register
  always @(posedge Clock) begin
    for (int i = 0; i < 4; i++) begin
      if (TSel[3-i]) rf_env[i]   <= rf_apply(FunSel, rf_env[i], RFInput);
      if (RSel[3-i]) rf_env[i+4] <= rf_apply(FunSel, rf_env[i+4], RFInput);
    end
  end

  function automatic logic [2:0] onehot_to_idx(input logic [3:0] r, input logic [3:0] t);
    logic [3:0] v;
    logic [1:0] pos;
    v = (r != 4'b0000) ? r : t;
    case (v)
      4'b1000: pos = 2'd0;
      4'b0100: pos = 2'd1;
      4'b0010: pos = 2'd2;
      default: pos = 2'd3;
    endcase
    return {(r != 4'b0000), pos};
  endfunction

  function automatic void push(input int kind, input logic [2:0] idx, input logic [1:0] fun,
                               input logic [7:0] data, input int when);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.fun  = fun;
    e.data = data;
    e.cyc  = when;
    sb.push_back(e);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  // Pop the oldest expectation and compare it with what the DUT just showed
  task automatic scoreEvent(input int kind, input logic [2:0] idx, input logic [1:0] fun,
                            input logic [7:0] data, input logic [2:0] o2);
    ev_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL unexpected_event: got kind=%0d idx=%0d at cycle %0d, required no event",
               kind, idx, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          (kind == EV_WRITE && (e.idx != idx || e.fun != fun || e.data != data || o2 != idx))) begin
        miscompares++;
        $display("[TB] FAIL event: got kind=%0d idx=%0d o2=%0d fun=%0d data=%0h cyc=%0d, required kind=%0d idx=%0d fun=%0d data=%0h cyc=%0d",
                 kind, idx, o2, fun, data, cyc, e.kind, e.idx, e.fun, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: sample away from the rising edge and score everything visible
  initial begin
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        if ((RSel | TSel) != 4'b0000) begin
          checkOutput("enable_onehot", 32'($countones({RSel, TSel})), 32'd1);
          scoreEvent(EV_WRITE, onehot_to_idx(RSel, TSel), FunSel, RFInput, O2Sel);
        end
        if (Done && Err) checkOutput("done_err_exclusive", {Done, Err}, 32'd0);
        if (Done) scoreEvent(EV_DONE, 3'b000, 2'b00, 8'h00, 3'b000);
        if (Err)  scoreEvent(EV_ERR, 3'b000, 2'b00, 8'h00, 3'b000);
        if (CmdReady && !prev_ready) scoreEvent(EV_READY, 3'b000, 2'b00, 8'h00, 3'b000);
      end
      prev_ready = CmdReady;
    end
  end

  // Issue one command: wait for ready while offering ignored garbage, then
  // record the expected writes/completion in the scoreboard from the command rules
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] dst,
                               input logic [2:0] src, input logic [7:0] imm);
    int c;
    int guard;
    logic [7:0] va;
    logic [7:0] vb;
    guard = 0;
    @(negedge Clock);
    while (!CmdReady && guard < 100) begin
      CmdValid = 1'($urandom);
      CmdOp    = 3'($urandom);
      CmdDst   = 3'($urandom);
      CmdSrc   = 3'($urandom);
      CmdImm   = 8'($urandom);
      @(negedge Clock);
      guard++;
    end
    if (!CmdReady) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ready_timeout: got CmdReady=0 for %0d cycles, required 1", guard);
      CmdValid = 1'b0;
      return;
    end
    c = cyc;
    CmdValid = 1'b1;
    CmdOp    = op;
    CmdDst   = dst;
    CmdSrc   = src;
    CmdImm   = imm;
    if (op == 3'b110 || op == 3'b111 || (op == 3'b101 && (dst == SCRATCH || src == SCRATCH))) begin
      push(EV_ERR, 3'b000, 2'b00, 8'h00, c + 1);
      push(EV_READY, 3'b000, 2'b00, 8'h00, c + 2);
    end else if (op == 3'b101 && dst == src) begin
      push(EV_DONE, 3'b000, 2'b00, 8'h00, c + 1);
      push(EV_READY, 3'b000, 2'b00, 8'h00, c + 2);
    end else if (op == 3'b101) begin
      va = ref_regs[dst];
      vb = ref_regs[src];
      push(EV_WRITE, SCRATCH, 2'b01, va, c + 2);
      push(EV_WRITE, dst, 2'b01, vb, c + 4);
      push(EV_WRITE, src, 2'b01, va, c + 6);
      push(EV_DONE, 3'b000, 2'b00, 8'h00, c + 7);
      push(EV_READY, 3'b000, 2'b00, 8'h00, c + 8);
      ref_regs[SCRATCH] = va;
      ref_regs[dst]     = vb;
      ref_regs[src]     = va;
    end else if (op == 3'b100) begin
      va = ref_regs[src];
      push(EV_WRITE, dst, 2'b01, va, c + 2);
      push(EV_DONE, 3'b000, 2'b00, 8'h00, c + 3);
      push(EV_READY, 3'b000, 2'b00, 8'h00, c + 4);
      ref_regs[dst] = va;
    end else begin
      case (op)
        3'b000: begin push(EV_WRITE, dst, 2'b00, 8'h00, c + 1); ref_regs[dst] = 8'h00; end
        3'b001: begin push(EV_WRITE, dst, 2'b01, imm, c + 1);   ref_regs[dst] = imm; end
        3'b010: begin push(EV_WRITE, dst, 2'b10, 8'h00, c + 1); ref_regs[dst] = ref_regs[dst] - 8'd1; end
        default: begin push(EV_WRITE, dst, 2'b11, 8'h00, c + 1); ref_regs[dst] = ref_regs[dst] + 8'd1; end
      endcase
      push(EV_DONE, 3'b000, 2'b00, 8'h00, c + 2);
      push(EV_READY, 3'b000, 2'b00, 8'h00, c + 3);
    end
    @(posedge Clock);
    #1;
    CmdValid = 1'b0;
    CmdOp    = 3'($urandom);
    CmdDst   = 3'($urandom);
    CmdSrc   = 3'($urandom);
    CmdImm   = 8'($urandom);
  endtask

  // SWAP R2,R3 interrupted by reset during its second read: only the scratch write lands
  task automatic resetDuringSwap();
    logic [7:0] saved [8];
    int k;
    int guard;
    saved = ref_regs;
    applyStimulus(3'b101, 3'b101, 3'b110, 8'h00);
    k = cyc;
    guard = 0;
    while (cyc != k + 2 && guard < 20) begin
      @(negedge Clock);
      guard++;
    end
    checkOutput("reset_point_reached", 32'(cyc), 32'(k + 2));
    #2;
    Reset = 1'b1;
    sb.delete();
    #1;
    checkOutput("enables_in_reset", {RSel, TSel}, 32'd0);
    checkOutput("done_err_in_reset", {Done, Err}, 32'd0);
    ref_regs = saved;
    ref_regs[SCRATCH] = saved[5];
    repeat (2) @(negedge Clock);
    #2;
    Reset = 1'b0;
    @(negedge Clock);
    checkOutput("after_abort_ready_enables", {CmdReady, RSel, TSel, Done, Err}, {1'b1, 10'd0});
  endtask

  // Directed scenarios, then randomized commands, then a final register check
  initial begin
    int guard;
    logic [2:0] op;
    logic [2:0] dst;
    logic [2:0] src;
    repeat (3) @(negedge Clock);
    #2;
    Reset = 1'b0;
    @(negedge Clock);
    checkOutput("reset_outputs",
                {FunSel, RSel, TSel, O1Sel, O2Sel, RFInput, Done, Err, CmdReady},
                {2'b00, 4'b0000, 4'b0000, 3'b000, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1});

    applyStimulus(3'b001, 3'b100, 3'b000, 8'hA5);
    applyStimulus(3'b001, 3'b100, 3'b000, 8'h3C);
    applyStimulus(3'b100, 3'b000, 3'b100, 8'h00);
    applyStimulus(3'b001, 3'b101, 3'b000, 8'h11);
    applyStimulus(3'b001, 3'b110, 3'b000, 8'h22);
    applyStimulus(3'b101, 3'b101, 3'b110, 8'h00);
    applyStimulus(3'b101, 3'b011, 3'b100, 8'h00);
    applyStimulus(3'b111, 3'b001, 3'b010, 8'h77);
    applyStimulus(3'b110, 3'b000, 3'b000, 8'h00);
    applyStimulus(3'b001, 3'b111, 3'b000, 8'hFF);
    applyStimulus(3'b011, 3'b111, 3'b000, 8'h00);
    applyStimulus(3'b000, 3'b000, 3'b000, 8'h00);
    applyStimulus(3'b010, 3'b000, 3'b000, 8'h00);
    applyStimulus(3'b101, 3'b010, 3'b010, 8'h00);
    applyStimulus(3'b100, 3'b110, 3'b110, 8'h00);
    resetDuringSwap();

    for (int n = 0; n < 250; n++) begin
      op  = 3'($urandom_range(0, 7));
      dst = 3'($urandom_range(0, 7));
      src = 3'($urandom_range(0, 7));
      if (op == 3'b101 && dst == SCRATCH && src == SCRATCH) src = 3'b100;
      applyStimulus(op, dst, src, 8'($urandom));
    end

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge Clock);
      guard++;
    end
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    @(negedge Clock);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("reg%0d", i), 32'(rf_env[i]), 32'(ref_regs[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
